// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and constants for the pipeline hazard unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic [0:0] {
        HZ_RUN     = 1'b0,
        HZ_MEMWAIT = 1'b1
    } hz_state_e;

    localparam logic [1:0] LOAD_RSRC_DEFAULT = 2'b01;

    // x0 is hard-wired zero, so a write to it never produces a forwardable value.
    function automatic logic reg_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit_if
//  Description : Pipeline-stage inputs and stall/flush/forward outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_unit_if
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
) ();
    logic [4:0]       Rs1_D, Rs2_D, Rs1_E, Rs2_E;
    logic [4:0]       Rd_E, Rd_M, Rd_W;
    logic [1:0]       ResultSrc_E;
    logic             RegWrite_M, RegWrite_W;
    logic [1:0]       PCSrc;
    logic             dmem_valid, dmem_ready;
    fwd_sel_e         ForwardA_E, ForwardB_E;
    logic             StallF, StallD, StallE, StallM, StallW;
    logic             FlushD, FlushE;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             mem_timeout;

    modport master (
        output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W, ResultSrc_E,
               RegWrite_M, RegWrite_W, PCSrc, dmem_valid, dmem_ready,
        input  ForwardA_E, ForwardB_E, StallF, StallD, StallE, StallM, StallW,
               FlushD, FlushE, stall_cnt, flush_cnt, mem_timeout
    );

    modport slave (
        input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W, ResultSrc_E,
               RegWrite_M, RegWrite_W, PCSrc, dmem_valid, dmem_ready,
        output ForwardA_E, ForwardB_E, StallF, StallD, StallE, StallM, StallW,
               FlushD, FlushE, stall_cnt, flush_cnt, mem_timeout
    );
endinterface
`default_nettype wire

// File: rtl/hazard_unit_fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_sel
//  Description : Forwarding select for one E-stage operand; M beats W.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] rd_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       regwrite_m_i,
    input  logic       regwrite_w_i,
    output fwd_sel_e   sel_o
);
    always_comb begin
        sel_o = FWD_RF;
        if (reg_hit(regwrite_m_i, rd_m_i, rs_i)) begin
            sel_o = FWD_M;
        end else if (reg_hit(regwrite_w_i, rd_w_i, rs_i)) begin
            sel_o = FWD_W;
        end
    end
endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit
//  Description : Stall/flush/forward resolver with perf counters and mem timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int         MAX_WAIT  = 16,
    parameter int         CNT_W     = 32,
    parameter logic [1:0] LOAD_RSRC = LOAD_RSRC_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    hazard_unit_if.slave hz
);
    localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);

    hz_state_e        state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       w_lwstall, w_redirect, w_memwait;
    logic       w_stall_fd, w_stall_emw, w_flush_d, w_flush_e;
    logic [7:0] w_wait_inc;

    fwd_sel u_fwd_a (
        .rs_i         (hz.Rs1_E),
        .rd_m_i       (hz.Rd_M),
        .rd_w_i       (hz.Rd_W),
        .regwrite_m_i (hz.RegWrite_M),
        .regwrite_w_i (hz.RegWrite_W),
        .sel_o        (hz.ForwardA_E)
    );

    fwd_sel u_fwd_b (
        .rs_i         (hz.Rs2_E),
        .rd_m_i       (hz.Rd_M),
        .rd_w_i       (hz.Rd_W),
        .regwrite_m_i (hz.RegWrite_M),
        .regwrite_w_i (hz.RegWrite_W),
        .sel_o        (hz.ForwardB_E)
    );

    assign w_lwstall  = (hz.ResultSrc_E == LOAD_RSRC) && (hz.Rd_E != 5'd0) &&
                        ((hz.Rd_E == hz.Rs1_D) || (hz.Rd_E == hz.Rs2_D));
    assign w_redirect = (hz.PCSrc != 2'b00);
    assign w_memwait  = hz.dmem_valid && !hz.dmem_ready;

    // A pending redirect is held in E during a freeze and taken once memory releases.
    always_comb begin
        w_stall_fd  = 1'b0;
        w_stall_emw = 1'b0;
        w_flush_d   = 1'b0;
        w_flush_e   = 1'b0;
        if (w_memwait) begin
            w_stall_fd  = 1'b1;
            w_stall_emw = 1'b1;
        end else if (w_redirect) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (w_lwstall) begin
            w_stall_fd = 1'b1;
            w_flush_e  = 1'b1;
        end
    end

    assign hz.StallF      = w_stall_fd;
    assign hz.StallD      = w_stall_fd;
    assign hz.StallE      = w_stall_emw;
    assign hz.StallM      = w_stall_emw;
    assign hz.StallW      = w_stall_emw;
    assign hz.FlushD      = w_flush_d;
    assign hz.FlushE      = w_flush_e;
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;
    assign hz.mem_timeout = timeout_q;

    assign w_wait_inc = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            HZ_RUN: begin
                if (w_memwait) begin
                    state_d    = HZ_MEMWAIT;
                    wait_cnt_d = 8'd0;
                end
            end
            HZ_MEMWAIT: begin
                if (w_memwait) begin
                    wait_cnt_d = w_wait_inc;
                    if (w_wait_inc == c_max_wait) begin
                        timeout_d = 1'b1;
                    end
                end else begin
                    state_d = HZ_RUN;
                end
            end
            default: state_d = HZ_RUN;
        endcase
        if (w_stall_fd && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (w_redirect && !w_memwait && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HZ_RUN;
            wait_cnt_q  <= 8'd0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_unit
//  Description : Directed self-checking bench for hazard_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_unit_if #(.CNT_W(32)) hz ();

    hazard_unit #(.MAX_WAIT(16), .CNT_W(32), .LOAD_RSRC(2'b01)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    typedef struct packed {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [4:0]  st;   // {F,D,E,M,W}
        logic [1:0]  fl;   // {D,E}
        logic [31:0] sc;
        logic [31:0] fc;
        logic        to;
    } exp_t;

    exp_t        sb_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] sc_m   = 32'd0;
    logic [31:0] fc_m   = 32'd0;

    task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp_v);
        end
    endtask

    task automatic quiet();
        hz.Rs1_D = 5'd0; hz.Rs2_D = 5'd0; hz.Rs1_E = 5'd0; hz.Rs2_E = 5'd0;
        hz.Rd_E = 5'd0; hz.Rd_M = 5'd0; hz.Rd_W = 5'd0; hz.ResultSrc_E = 2'b00;
        hz.RegWrite_M = 1'b0; hz.RegWrite_W = 1'b0; hz.PCSrc = 2'b00;
        hz.dmem_valid = 1'b0; hz.dmem_ready = 1'b0;
    endtask

    // One cycle: record expectation, compare in the low half, then advance the model.
    task automatic cyc(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [4:0] st, input logic [1:0] fl, input logic to,
                       input logic take_flush);
        exp_t e;
        string t;
        sb_q.push_back('{fa: fa, fb: fb, st: st, fl: fl, sc: sc_m, fc: fc_m, to: to});
        tag_q.push_back(tag);
        #2;
        checks++;
        assert (sb_q.size() > 0) else begin
            errors++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            chk(t, "ForwardA_E", 32'(hz.ForwardA_E), 32'(e.fa));
            chk(t, "ForwardB_E", 32'(hz.ForwardB_E), 32'(e.fb));
            chk(t, "Stall", 32'({hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.StallW}), 32'(e.st));
            chk(t, "Flush", 32'({hz.FlushD, hz.FlushE}), 32'(e.fl));
            chk(t, "stall_cnt", hz.stall_cnt, e.sc);
            chk(t, "flush_cnt", hz.flush_cnt, e.fc);
            chk(t, "mem_timeout", 32'(hz.mem_timeout), 32'(e.to));
        end
        if (rst) begin
            sc_m = 32'd0;
            fc_m = 32'd0;
        end else begin
            if (st[4]) sc_m++;
            if (take_flush) fc_m++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        quiet();
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset0", 2'b00, 2'b00, 5'b00000, 2'b00, 1'b0, 1'b0);
        cyc("reset1", 2'b00, 2'b00, 5'b00000, 2'b00, 1'b0, 1'b0);
        rst = 1'b0;
        cyc("idle", 2'b00, 2'b00, 5'b00000, 2'b00, 1'b0, 1'b0);

        // Forwarding
        hz.Rd_M = 5'd5; hz.RegWrite_M = 1'b1; hz.Rd_W = 5'd5; hz.RegWrite_W = 1'b1;
        hz.Rs1_E = 5'd5; hz.Rs2_E = 5'd5;
        cyc("fwd_m_beats_w", 2'b10, 2'b10, 5'b00000, 2'b00, 1'b0, 1'b0);
        hz.Rd_M = 5'd0;
        cyc("fwd_w_rdm0", 2'b01, 2'b01, 5'b00000, 2'b00, 1'b0, 1'b0);
        hz.Rd_M = 5'd5; hz.RegWrite_M = 1'b0; hz.Rs2_E = 5'd3;
        cyc("fwd_w_nowe_m", 2'b01, 2'b00, 5'b00000, 2'b00, 1'b0, 1'b0);
        hz.RegWrite_M = 1'b1; hz.RegWrite_W = 1'b0; hz.Rd_W = 5'd3;
        cyc("fwd_m_a_none_b", 2'b10, 2'b00, 5'b00000, 2'b00, 1'b0, 1'b0);
        quiet();
        hz.Rs1_E = 5'd0; hz.Rd_M = 5'd0; hz.RegWrite_M = 1'b1; hz.Rd_W = 5'd0; hz.RegWrite_W = 1'b1;
        cyc("fwd_x0", 2'b00, 2'b00, 5'b00000, 2'b00, 1'b0, 1'b0);

        // Load-use stall: one bubble, then the load has moved on
        quiet();
        hz.ResultSrc_E = 2'b01; hz.Rd_E = 5'd7; hz.Rs2_D = 5'd7;
        cyc("lwstall", 2'b00, 2'b00, 5'b11000, 2'b01, 1'b0, 1'b0);
        quiet();
        hz.Rs2_D = 5'd7;
        cyc("lwstall_done", 2'b00, 2'b00, 5'b00000, 2'b00, 1'b0, 1'b0);
        hz.ResultSrc_E = 2'b01; hz.Rd_E = 5'd0; hz.Rs1_D = 5'd0;
        cyc("lw_rd0", 2'b00, 2'b00, 5'b00000, 2'b00, 1'b0, 1'b0);
        hz.ResultSrc_E = 2'b10; hz.Rd_E = 5'd7; hz.Rs1_D = 5'd7;
        cyc("non_load", 2'b00, 2'b00, 5'b00000, 2'b00, 1'b0, 1'b0);

        // Redirect beats load-use
        hz.ResultSrc_E = 2'b01; hz.PCSrc = 2'b01;
        cyc("redirect", 2'b00, 2'b00, 5'b00000, 2'b11, 1'b0, 1'b1);
        quiet();
        cyc("after_redirect", 2'b00, 2'b00, 5'b00000, 2'b00, 1'b0, 1'b0);

        // Memory freeze with a redirect held in E
        hz.dmem_valid = 1'b1; hz.dmem_ready = 1'b0; hz.PCSrc = 2'b10;
        for (int i = 0; i < 4; i++) begin
            cyc($sformatf("memwait%0d", i), 2'b00, 2'b00, 5'b11111, 2'b00, 1'b0, 1'b0);
        end
        hz.dmem_ready = 1'b1;
        cyc("mem_release", 2'b00, 2'b00, 5'b00000, 2'b11, 1'b0, 1'b1);
        quiet();
        cyc("after_release", 2'b00, 2'b00, 5'b00000, 2'b00, 1'b0, 1'b0);

        // Timeout: sets after the 17th waiting cycle
        hz.dmem_valid = 1'b1; hz.dmem_ready = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc($sformatf("timeout_c%0d", k), 2'b00, 2'b00, 5'b11111, 2'b00, (k >= 18), 1'b0);
        end
        rst = 1'b1;
        cyc("rst_midwait", 2'b00, 2'b00, 5'b11111, 2'b00, 1'b1, 1'b0);
        rst = 1'b0;
        quiet();
        cyc("post_rst", 2'b00, 2'b00, 5'b00000, 2'b00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
